// File: rtl/stackcalc_pkg.sv
// Shared constants for the stack calculator: opcodes, FSM encoding, ALU select
// and the default word width and stack depth.
package stackcalc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_DUP  = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR
    } alu_op_e;

endpackage

// File: rtl/stack_alu.sv
// Combinational binary operator for the stack engine.
// A is top-of-stack, B is the entry below it; the result is B op A.
module stack_alu
    import stackcalc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        result_o = b_i + a_i;
        case (op_i)
            ALU_SUB: result_o = b_i - a_i;
            ALU_XOR: result_o = b_i ^ a_i;
            default: result_o = b_i + a_i;
        endcase
    end

endmodule

// File: rtl/stack_engine.sv
// Three-phase (IDLE/EXEC/DONE) stack calculator with overflow/underflow detection
// and a sticky error flag. Entry 0 is the bottom of the stack.
module stack_engine
    import stackcalc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               opcode,
    input  logic [WIDTH-1:0]         operand,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     done,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;
    logic [PW-1:0]    tos_idx, nos_idx, new_idx;
    logic [WIDTH-1:0] tos, nos, alu_res;
    alu_op_e          alu_op;
    logic             accept;

    assign accept  = cmd_valid && cmd_ready;
    assign tos_idx = PW'(depth_q - DW'(1));
    assign nos_idx = PW'(depth_q - DW'(2));
    assign new_idx = PW'(depth_q);
    assign tos     = stack_q[tos_idx];
    assign nos     = stack_q[nos_idx];

    always_comb begin
        alu_op = ALU_ADD;
        if (op_q == OP_SUB)      alu_op = ALU_SUB;
        else if (op_q == OP_XOR) alu_op = ALU_XOR;
    end

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i     (alu_op),
        .a_i      (tos),
        .b_i      (nos),
        .result_o (alu_res)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Faulting commands leave the stack untouched and only raise err.
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        err_d   = err_q;
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_PUSH: begin
                    if (depth_q == FULL) err_d = 1'b1;
                    else begin
                        stack_d[new_idx] = operand_q;
                        depth_d          = depth_q + DW'(1);
                    end
                end
                OP_POP: begin
                    if (depth_q == '0) err_d = 1'b1;
                    else depth_d = depth_q - DW'(1);
                end
                OP_ADD, OP_SUB, OP_XOR: begin
                    if (depth_q < DW'(2)) err_d = 1'b1;
                    else begin
                        stack_d[nos_idx] = alu_res;
                        depth_d          = depth_q - DW'(1);
                    end
                end
                OP_DUP: begin
                    if (depth_q == '0 || depth_q == FULL) err_d = 1'b1;
                    else begin
                        stack_d[new_idx] = tos;
                        depth_d          = depth_q + DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (depth_q < DW'(2)) err_d = 1'b1;
                    else begin
                        stack_d[tos_idx] = nos;
                        stack_d[nos_idx] = tos;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            operand_q <= '0;
            depth_q   <= '0;
            err_q     <= 1'b0;
            // NOTE: the storage array is reset here because a cleared stack is visible behaviour.
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= opcode;
                operand_q <= operand;
            end
            stack_q <= stack_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign depth     = depth_q;
    assign top       = (depth_q == '0) ? '0 : tos;

endmodule

// File: tb/tb_stack_engine.sv
// Table-driven bench for stack_engine: expected results are queued when a command
// is issued and compared when done pulses; hand sequences cover timing and reset.
module tb_stack_engine;
    import stackcalc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] opcode;
    logic [7:0] operand;
    logic [7:0] top;
    logic [2:0] depth;
    logic       done;
    logic       err;

    stack_engine #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .opcode    (opcode),
        .operand   (operand),
        .top       (top),
        .depth     (depth),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_before;
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] top;
        logic [2:0] depth;
        logic       err;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] top;
        logic [2:0] depth;
        logic       err;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec      = 0;
    int   n_miscmp   = 0;
    int   done_count = 0;
    logic prev_done  = 1'b0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miscmp++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, act, want);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] op, input logic [7:0] d,
                                input logic [7:0] t, input logic [2:0] dp, input logic e);
        vec_t v;
        v.rst_before = r; v.op = op; v.data = d; v.top = t; v.depth = dp; v.err = e;
        return v;
    endfunction

    function automatic exp_t mk_exp(input int idx, input logic [7:0] t, input logic [2:0] dp, input logic e);
        exp_t x;
        x.idx = idx; x.top = t; x.depth = dp; x.err = e;
        return x;
    endfunction

    // Scoreboard side: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_count++;
            check("done_width", done_count, 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) check("unexpected_done", done_count, 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("top", e.idx, 32'(top), 32'(e.top));
                check("depth", e.idx, 32'(depth), 32'(e.depth));
                check("err", e.idx, 32'(err), 32'(e.err));
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_reset(input int tag);
        check("rst_top", tag, 32'(top), 32'd0);
        check("rst_depth", tag, 32'(depth), 32'd0);
        check("rst_err", tag, 32'(err), 32'd0);
        check("rst_ready", tag, 32'(cmd_ready), 32'd1);
        check("rst_done", tag, 32'(done), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", n, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic issue(input int idx, input logic [2:0] op, input logic [7:0] d, input exp_t e);
        int n = 0;
        while (!cmd_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", idx, 32'(cmd_ready), 32'd1);
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        opcode    = op;
        operand   = d;
        @(posedge clk); #1;
        // Garbage while busy must be ignored.
        cmd_valid = 1'b0;
        opcode    = 3'($urandom);
        operand   = 8'($urandom);
    endtask

    initial begin
        int acc_q[$];
        int dc0;

        rst = 1'b1; cmd_valid = 1'b0; opcode = OP_NOP; operand = '0;

        vecs.push_back(mk(1, OP_PUSH, 8'h05, 8'h05, 3'd1, 1'b0));
        vecs.push_back(mk(0, OP_PUSH, 8'h03, 8'h03, 3'd2, 1'b0));
        vecs.push_back(mk(0, OP_ADD,  8'h00, 8'h08, 3'd1, 1'b0));
        vecs.push_back(mk(1, OP_PUSH, 8'h02, 8'h02, 3'd1, 1'b0));
        vecs.push_back(mk(0, OP_PUSH, 8'h05, 8'h05, 3'd2, 1'b0));
        vecs.push_back(mk(0, OP_SUB,  8'h00, 8'hFD, 3'd1, 1'b0));
        vecs.push_back(mk(1, OP_PUSH, 8'h11, 8'h11, 3'd1, 1'b0));
        vecs.push_back(mk(0, OP_PUSH, 8'h22, 8'h22, 3'd2, 1'b0));
        vecs.push_back(mk(0, OP_PUSH, 8'h33, 8'h33, 3'd3, 1'b0));
        vecs.push_back(mk(0, OP_PUSH, 8'h44, 8'h44, 3'd4, 1'b0));
        vecs.push_back(mk(0, OP_PUSH, 8'h55, 8'h44, 3'd4, 1'b1));
        vecs.push_back(mk(0, OP_POP,  8'h00, 8'h33, 3'd3, 1'b1));
        vecs.push_back(mk(1, OP_POP,  8'h00, 8'h00, 3'd0, 1'b1));
        vecs.push_back(mk(0, OP_PUSH, 8'hA0, 8'hA0, 3'd1, 1'b1));
        vecs.push_back(mk(1, OP_PUSH, 8'h0F, 8'h0F, 3'd1, 1'b0));
        vecs.push_back(mk(0, OP_PUSH, 8'hF0, 8'hF0, 3'd2, 1'b0));
        vecs.push_back(mk(0, OP_SWAP, 8'h00, 8'h0F, 3'd2, 1'b0));
        vecs.push_back(mk(0, OP_DUP,  8'h00, 8'h0F, 3'd3, 1'b0));
        vecs.push_back(mk(0, OP_XOR,  8'h00, 8'h00, 3'd2, 1'b0));
        vecs.push_back(mk(0, OP_NOP,  8'hEE, 8'h00, 3'd2, 1'b0));
        vecs.push_back(mk(1, OP_PUSH, 8'h80, 8'h80, 3'd1, 1'b0));
        vecs.push_back(mk(0, OP_SWAP, 8'h00, 8'h80, 3'd1, 1'b1));
        vecs.push_back(mk(0, OP_DUP,  8'h00, 8'h80, 3'd2, 1'b1));
        vecs.push_back(mk(0, OP_ADD,  8'h00, 8'h00, 3'd1, 1'b1));
        vecs.push_back(mk(1, OP_ADD,  8'h00, 8'h00, 3'd0, 1'b1));
        vecs.push_back(mk(0, OP_PUSH, 8'h07, 8'h07, 3'd1, 1'b1));
        vecs.push_back(mk(0, OP_DUP,  8'h00, 8'h07, 3'd2, 1'b1));
        vecs.push_back(mk(0, OP_DUP,  8'h00, 8'h07, 3'd3, 1'b1));
        vecs.push_back(mk(0, OP_DUP,  8'h00, 8'h07, 3'd4, 1'b1));
        vecs.push_back(mk(0, OP_DUP,  8'h00, 8'h07, 3'd4, 1'b1));
        vecs.push_back(mk(0, OP_XOR,  8'h00, 8'h00, 3'd3, 1'b1));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset(0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) begin
                drain();
                do_reset();
                check_reset(i);
            end
            issue(i, vecs[i].op, vecs[i].data, mk_exp(i, vecs[i].top, vecs[i].depth, vecs[i].err));
        end
        drain();

        // cmd_valid held high: acceptances must be exactly 3 cycles apart.
        do_reset();
        opcode = OP_PUSH; operand = 8'h3C; cmd_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc_q.push_back(c);
                exp_q.push_back(mk_exp(100 + acc_q.size(), 8'h3C, 3'(acc_q.size()), 1'b0));
            end
        end
        cmd_valid = 1'b0;
        check("accept_count", 100, 32'(acc_q.size()), 32'd3);
        for (int i = 1; i < acc_q.size(); i++)
            check("accept_spacing", 100 + i, 32'(acc_q[i] - acc_q[i-1]), 32'd3);
        drain();

        // Reset during EXEC aborts the command without a done pulse.
        dc0 = done_count;
        cmd_valid = 1'b1; opcode = OP_PUSH; operand = 8'h77;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("exec_rst_depth", 200, 32'(depth), 32'd0);
        check("exec_rst_top", 200, 32'(top), 32'd0);
        check("exec_rst_ready", 200, 32'(cmd_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("exec_rst_no_done", 200, 32'(done_count - dc0), 32'd0);

        // Reset wins over a same-cycle acceptance.
        dc0 = done_count;
        cmd_valid = 1'b1; opcode = OP_PUSH; operand = 8'h99; rst = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; rst = 1'b0;
        check("rst_prio_ready", 300, 32'(cmd_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rst_prio_depth", 300, 32'(depth), 32'd0);
        check("rst_prio_no_done", 300, 32'(done_count - dc0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data word width.
REQ-002 SHALL have parameter DEPTH, default 4, the number of stack entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  engine can accept a command.
REQ-007 SHALL have port opcode  input  3  operation select.
REQ-008 SHALL have port operand  input  WIDTH  parallel word from the upstream shift register, used by PUSH.
REQ-009 SHALL have port top  output  WIDTH  current top-of-stack, 0 when empty.
REQ-010 SHALL have port depth  output  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  sticky error flag.

Function
REQ-013 SHALL decode opcodes as: 0 NOP, 1 PUSH operand, 2 POP, 3 ADD, 4 SUB, 5 XOR, 6 DUP, 7 SWAP.
REQ-014 SHALL accept a command when cmd_valid and cmd_ready are both high on a rising edge; SHALL latch opcode and operand at that edge.
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; IDLE leaves only on acceptance; EXEC and DONE last exactly one cycle each.
REQ-016 SHALL drive cmd_ready high only in IDLE; throughput one command per 3 cycles.
REQ-017 SHALL update stack contents and depth at the end of the EXEC cycle; top and depth show the new values during DONE.
REQ-018 SHALL assert done for exactly the DONE cycle, for every accepted command including NOP and errored commands.
REQ-019 ADD SHALL pop A (top) and B (next), push (B+A) mod 2^WIDTH; depth decreases by 1.
REQ-020 SUB SHALL push (B-A) mod 2^WIDTH; XOR SHALL push B^A; both depth -1.
REQ-021 DUP SHALL push a copy of top; SWAP SHALL exchange top and next, depth unchanged.
REQ-022 Overflow: PUSH or DUP at depth==DEPTH SHALL leave stack unchanged and set err.
REQ-023 Underflow: POP or DUP at depth==0, or ADD/SUB/XOR/SWAP at depth<2, SHALL leave stack unchanged and set err.
REQ-024 err SHALL remain set until rst; subsequent valid commands still execute normally.
REQ-025 SHALL ignore opcode, operand and cmd_valid while not in IDLE.

Reset
REQ-026 rst SHALL force FSM to IDLE, all entries to 0, depth 0, top 0, done 0, err 0, cmd_ready 1 on the next cycle.
REQ-027 rst asserted during EXEC or DONE SHALL abort the command with no stack update and no done pulse.
REQ-028 rst SHALL take priority over command acceptance in the same cycle.

Structure
REQ-029 Opcode constants, FSM state encoding and default WIDTH/DEPTH SHALL live in shared package stackcalc_pkg.
REQ-030 Binary arithmetic (ADD/SUB/XOR of A,B) SHALL be a combinational sub-module stack_alu; stack storage and FSM stay in stack_engine.

Verification
REQ-031 After reset: PUSH 0x05, PUSH 0x03, ADD -> top 0x08, depth 1, done once per command, err 0.
REQ-032 PUSH 0x02, PUSH 0x05, SUB -> top 0xFD (wrap), depth 1.
REQ-033 PUSH 0x11,0x22,0x33,0x44 then PUSH 0x55 -> err 1, top 0x44, depth 4; then POP -> top 0x33, depth 3.
REQ-034 Empty stack POP -> err 1, depth 0, top 0, done pulses; then PUSH 0xA0 -> top 0xA0, depth 1.
REQ-035 PUSH 0x0F, PUSH 0xF0, SWAP -> top 0x0F; DUP -> depth 3, top 0x0F; XOR -> top 0x00, depth 2.
REQ-036 cmd_valid held high continuously: acceptances spaced exactly 3 cycles; rst during EXEC of PUSH 0x77 -> depth 0, no done.
